// File: rtl/linebuf_pp_if.sv
// Bus interface for linebuf_pp: display read port, draw write port, swap control and status.
// The slave modport belongs to the buffer; the master modport belongs to the sprite engine.
interface linebuf_pp_if #(
  parameter int AW = 9,
  parameter int DW = 11
);
  logic          o_ready;
  logic          i_swap;
  logic          o_bank;
  logic          i_rd_en;
  logic [AW-1:0] i_rd_adr;
  logic [DW-1:0] o_rd_dat;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_adr;
  logic [DW-1:0] i_wr_dat;
  logic          o_coll;

  modport slave (
    input  i_swap, i_rd_en, i_rd_adr, i_wr_en, i_wr_adr, i_wr_dat,
    output o_ready, o_bank, o_rd_dat, o_coll
  );

  modport master (
    output i_swap, i_rd_en, i_rd_adr, i_wr_en, i_wr_adr, i_wr_dat,
    input  o_ready, o_bank, o_rd_dat, o_coll
  );
endinterface

// File: rtl/linebuf_pp.sv
// Ping-pong scanline buffer: first-wins draw pipeline, read-and-clear display bank, init sweep.
// Optional collision pulse output is enabled with the LINEBUF_COLLISION_EN macro.
module linebuf_pp #(
  parameter int            AW     = 9,
  parameter int            DW     = 11,
  parameter logic [DW-1:0] TRANSP = {DW{1'b0}}
) (
  input logic           clk,
  input logic           reset,
  linebuf_pp_if.slave   bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_ready;
  logic          r_bank;
  logic [DW-1:0] r_rd_dat;
  logic [DW-1:0] r_mem [2][DEPTH];

  logic          r_s1_vld;
  logic          r_s1_tag;
  logic [AW-1:0] r_s1_adr;
  logic [DW-1:0] r_s1_dat;
  logic          r_s2_we;
  logic          r_s2_tag;
  logic [AW-1:0] r_s2_adr;
  logic [DW-1:0] r_s2_dat;

  logic          w_run;
  logic          w_fwd;
  logic [DW-1:0] w_old;
  logic          w_old_empty;
  logic          w_new_full;

  assign w_run       = (r_state == ST_RUN);
  // The S2 commit has not reached the RAM yet, so a same-location S1 read must see its data.
  assign w_fwd       = r_s2_we && (r_s2_tag == r_s1_tag) && (r_s2_adr == r_s1_adr);
  assign w_old       = w_fwd ? r_s2_dat : r_mem[r_s1_tag][r_s1_adr];
  assign w_old_empty = (w_old == TRANSP);
  assign w_new_full  = (r_s1_dat != TRANSP);

  // Sweep/run state machine, bank select, display read register and write pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_cnt    <= {AW{1'b0}};
      r_ready  <= 1'b0;
      r_bank   <= 1'b0;
      r_rd_dat <= TRANSP;
      r_s1_vld <= 1'b0;
      r_s1_tag <= 1'b0;
      r_s1_adr <= {AW{1'b0}};
      r_s1_dat <= TRANSP;
      r_s2_we  <= 1'b0;
      r_s2_tag <= 1'b0;
      r_s2_adr <= {AW{1'b0}};
      r_s2_dat <= TRANSP;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
          if (r_cnt == {AW{1'b1}}) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.i_swap) begin
            r_bank <= ~r_bank;
          end
          if (bus.i_rd_en) begin
            r_rd_dat <= r_mem[r_bank][bus.i_rd_adr];
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= {AW{1'b0}};
          r_ready <= 1'b0;
        end
      endcase
      // The draw bank is captured at acceptance so a later swap cannot redirect the write.
      r_s1_vld <= w_run && bus.i_wr_en;
      r_s1_tag <= ~r_bank;
      r_s1_adr <= bus.i_wr_adr;
      r_s1_dat <= bus.i_wr_dat;
      r_s2_we  <= r_s1_vld && w_old_empty && w_new_full;
      r_s2_tag <= r_s1_tag;
      r_s2_adr <= r_s1_adr;
      r_s2_dat <= r_s1_dat;
    end
  end

  // Bank storage: sweep clear, then read-clear, with the S2 commit ordered last so it wins.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[0][r_cnt] <= TRANSP;
      r_mem[1][r_cnt] <= TRANSP;
    end else begin
      if (bus.i_rd_en) begin
        r_mem[r_bank][bus.i_rd_adr] <= TRANSP;
      end
      if (r_s2_we) begin
        r_mem[r_s2_tag][r_s2_adr] <= r_s2_dat;
      end
    end
  end

`ifdef LINEBUF_COLLISION_EN
  logic r_coll;

  // Collision flag is decided in S1 so that it is high during the S2 cycle of that write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= r_s1_vld && !w_old_empty && w_new_full;
    end
  end

  assign bus.o_coll = r_coll;
`else
  assign bus.o_coll = 1'b0;
`endif

  assign bus.o_ready  = r_ready;
  assign bus.o_bank   = r_bank;
  assign bus.o_rd_dat = r_rd_dat;
endmodule
